// File: rtl/uart_rx_oversample.sv
// -----------------------------------------------------------------------------
// uart_rx_oversample
// Oversampling UART receiver (8 data bits, optional even/odd parity, one or two
// stop bits). The serial line is synchronised and sampled p_oversample times
// per bit. Each received byte is presented with its error flags in a one-entry
// valid/ready holding register.
//
// Optional feature macro: UART_RX_NOISE_DETECT_EN
//   defined   : bit value = majority of three samples around mid-bit, and any
//               disagreement anywhere in the frame raises noise_err_o
//   undefined : single sample at mid-bit, noise_err_o tied low
// -----------------------------------------------------------------------------
module uart_rx_oversample #(
    parameter int p_clk_speed_hz = 100_000_000,
    parameter int p_baud_rate    = 115200,
    parameter int p_oversample   = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enable_i,
    input  logic       data_i,
    input  logic       parity_en_i,
    input  logic       parity_sel_i,
    input  logic       stop_sel_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    input  logic       data_ready_i,
    output logic       busy_o,
    output logic       parity_err_o,
    output logic       framing_err_o,
    output logic       noise_err_o,
    output logic       overrun_err_o
);

    // Clock cycles per oversample tick (floor), at least one.
    localparam int c_div    = p_clk_speed_hz / (p_baud_rate * p_oversample);
    localparam int c_tick_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int c_samp_w = $clog2(p_oversample);

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(c_div - 1);
    localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);
    localparam logic [c_samp_w-1:0] c_samp_last = c_samp_w'(p_oversample - 1);
    localparam logic [c_samp_w-1:0] c_samp_one  = c_samp_w'(1);

`ifdef UART_RX_NOISE_DETECT_EN
    // Three samples straddle mid-bit; the decision is made on the last one.
    localparam logic [c_samp_w-1:0] c_samp_pre    = c_samp_w'(p_oversample / 2 - 1);
    localparam logic [c_samp_w-1:0] c_samp_mid    = c_samp_w'(p_oversample / 2);
    localparam logic [c_samp_w-1:0] c_samp_decide = c_samp_w'(p_oversample / 2 + 1);
`else
    localparam logic [c_samp_w-1:0] c_samp_decide = c_samp_w'(p_oversample / 2);
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_STOP2  = 3'd5
    } state_t;

    // Expected parity bit: even -> XOR of data, odd -> inverted.
    function automatic logic calc_parity(input logic [7:0] d, input logic odd);
        calc_parity = (^d) ^ odd;
    endfunction

`ifdef UART_RX_NOISE_DETECT_EN
    // Two-of-three vote.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        majority3 = (a & b) | (a & c) | (b & c);
    endfunction
`endif

    state_t                state_r;
    state_t                state_nxt_s;
    logic [1:0]            sync_r;
    logic                  line_s;
    logic                  line_prev_r;
    logic                  fall_s;
    logic [c_tick_w-1:0]   tick_cnt_r;
    logic [c_samp_w-1:0]   samp_cnt_r;
    logic                  tick_s;
    logic                  decide_s;
    logic                  bit_val_s;
    logic                  disagree_s;
    logic [2:0]            bit_cnt_r;
    logic [7:0]            shift_r;
    logic                  par_en_r;
    logic                  par_odd_r;
    logic                  stop2_r;
    logic                  par_err_acc_r;
    logic                  frm_err_acc_r;
    logic                  noise_acc_r;
    logic                  start_s;
    logic                  complete_s;
    logic                  load_s;
    logic [7:0]            data_r;
    logic                  valid_r;
    logic                  busy_r;
    logic                  par_err_r;
    logic                  frm_err_r;
    logic                  noise_err_r;
    logic                  overrun_r;

`ifdef UART_RX_NOISE_DETECT_EN
    logic                  samp_a_r;
    logic                  samp_b_r;
`endif

    // Two-flop synchroniser, preset to idle-high, plus previous value for edge detect.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_r      <= 2'b11;
            line_prev_r <= 1'b1;
        end else begin
            sync_r      <= {sync_r[0], data_i};
            line_prev_r <= sync_r[1];
        end
    end

    assign line_s = sync_r[1];
    assign fall_s = line_prev_r & ~line_s;
    assign tick_s = (tick_cnt_r == c_tick_last);
    assign decide_s = (state_r != ST_IDLE) && tick_s && (samp_cnt_r == c_samp_decide);

    // Tick divider and per-bit sample counter; both parked at zero while idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tick_cnt_r <= '0;
            samp_cnt_r <= '0;
        end else if (state_r == ST_IDLE) begin
            tick_cnt_r <= '0;
            samp_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
            samp_cnt_r <= (samp_cnt_r == c_samp_last) ? '0 : (samp_cnt_r + c_samp_one);
        end else begin
            tick_cnt_r <= tick_cnt_r + c_tick_one;
        end
    end

`ifdef UART_RX_NOISE_DETECT_EN
    // Capture the two samples that precede the decision sample.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            samp_a_r <= 1'b1;
            samp_b_r <= 1'b1;
        end else begin
            if (tick_s && (samp_cnt_r == c_samp_pre)) begin
                samp_a_r <= line_s;
            end
            if (tick_s && (samp_cnt_r == c_samp_mid)) begin
                samp_b_r <= line_s;
            end
        end
    end

    // Majority vote and disagreement detect for the current bit.
    always_comb begin
        bit_val_s  = majority3(samp_a_r, samp_b_r, line_s);
        disagree_s = ~((samp_a_r == samp_b_r) && (samp_b_r == line_s));
    end
`else
    // Single mid-bit sample; no disagreement possible.
    always_comb begin
        bit_val_s  = line_s;
        disagree_s = 1'b0;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; every transition after START happens at a bit decision point.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        complete_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable_i && fall_s) begin
                    state_nxt_s = ST_START;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (decide_s) begin
                    state_nxt_s = bit_val_s ? ST_IDLE : ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (decide_s && (bit_cnt_r == 3'd7)) begin
                    state_nxt_s = par_en_r ? ST_PARITY : ST_STOP;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (decide_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (decide_s && stop2_r) begin
                    state_nxt_s = ST_STOP2;
                end else if (decide_s) begin
                    state_nxt_s = ST_IDLE;
                    complete_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_STOP2: begin
                if (decide_s) begin
                    state_nxt_s = ST_IDLE;
                    complete_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_STOP2;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: latch frame config, shift data LSB first, accumulate errors.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_cnt_r     <= 3'd0;
            shift_r       <= 8'h00;
            par_en_r      <= 1'b0;
            par_odd_r     <= 1'b0;
            stop2_r       <= 1'b0;
            par_err_acc_r <= 1'b0;
            frm_err_acc_r <= 1'b0;
            noise_acc_r   <= 1'b0;
        end else if (start_s) begin
            bit_cnt_r     <= 3'd0;
            par_en_r      <= parity_en_i;
            par_odd_r     <= parity_sel_i;
            stop2_r       <= stop_sel_i;
            par_err_acc_r <= 1'b0;
            frm_err_acc_r <= 1'b0;
            noise_acc_r   <= 1'b0;
        end else if (decide_s) begin
            noise_acc_r <= noise_acc_r | disagree_s;
            case (state_r)
                ST_DATA: begin
                    shift_r   <= {bit_val_s, shift_r[7:1]};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
                ST_PARITY: begin
                    par_err_acc_r <= (bit_val_s != calc_parity(shift_r, par_odd_r));
                end
                ST_STOP: begin
                    frm_err_acc_r <= frm_err_acc_r | ~bit_val_s;
                end
                default: begin
                    bit_cnt_r <= bit_cnt_r;
                end
            endcase
        end
    end

    // A finished frame is accepted when the holding register is empty or being drained.
    assign load_s = complete_s & (~valid_r | data_ready_i);

    // Holding register with flags, overrun pulse and busy indication.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_r      <= 8'h00;
            valid_r     <= 1'b0;
            par_err_r   <= 1'b0;
            frm_err_r   <= 1'b0;
            noise_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (load_s) begin
                data_r      <= shift_r;
                valid_r     <= 1'b1;
                par_err_r   <= par_err_acc_r;
                frm_err_r   <= frm_err_acc_r | ~bit_val_s;
                noise_err_r <= noise_acc_r | disagree_s;
            end else if (valid_r && data_ready_i) begin
                valid_r <= 1'b0;
            end
            overrun_r <= complete_s & ~load_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
        end
    end

    assign data_o        = data_r;
    assign data_valid_o  = valid_r;
    assign busy_o        = busy_r;
    assign parity_err_o  = par_err_r;
    assign framing_err_o = frm_err_r;
    assign overrun_err_o = overrun_r;
`ifdef UART_RX_NOISE_DETECT_EN
    assign noise_err_o   = noise_err_r;
`else
    assign noise_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversample
// Directed bench for uart_rx_oversample. Frames are generated bit by bit; the
// expected byte and flags are queued when a frame is sent and compared against
// what the monitor captures on each valid/ready handshake.
// Optional feature macro: UART_RX_NOISE_DETECT_EN (enables the glitch step).
// -----------------------------------------------------------------------------
module tb_uart_rx_oversample;

    // 3.2 MHz / (100 kbaud * 16) -> tick every 2 clocks, 32 clocks per bit.
    localparam int c_bit = 32;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
        logic       n;
    } rx_t;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       enable_i;
    logic       data_i;
    logic       parity_en_i;
    logic       parity_sel_i;
    logic       stop_sel_i;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       data_ready_i;
    logic       busy_o;
    logic       parity_err_o;
    logic       framing_err_o;
    logic       noise_err_o;
    logic       overrun_err_o;

    rx_t exp_q[$];
    rx_t rx_q[$];
    int  n_checks   = 0;
    int  n_pass     = 0;
    int  n_fail     = 0;
    int  vcycles    = 0;
    int  ovr_cnt    = 0;
    logic busy_seen = 1'b0;

    uart_rx_oversample #(
        .p_clk_speed_hz(3_200_000),
        .p_baud_rate   (100_000),
        .p_oversample  (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .enable_i     (enable_i),
        .data_i       (data_i),
        .parity_en_i  (parity_en_i),
        .parity_sel_i (parity_sel_i),
        .stop_sel_i   (stop_sel_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .busy_o       (busy_o),
        .parity_err_o (parity_err_o),
        .framing_err_o(framing_err_o),
        .noise_err_o  (noise_err_o),
        .overrun_err_o(overrun_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor on the falling edge: handshakes, valid duration, overrun pulses, busy.
    always @(negedge clk_i) begin
        if (data_valid_o) vcycles = vcycles + 1;
        if (overrun_err_o) ovr_cnt = ovr_cnt + 1;
        if (busy_o) busy_seen = 1'b1;
        if (data_valid_o && data_ready_i)
            rx_q.push_back('{d: data_o, p: parity_err_o, f: framing_err_o, n: noise_err_o});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        data_i = v;
        repeat (c_bit) @(negedge clk_i);
    endtask

    task automatic idle_bits(input int n);
        data_i = 1'b1;
        repeat (n * c_bit) @(negedge clk_i);
    endtask

    // One frame; glitch_bit >= 0 inverts that data bit for one sample period at mid-bit.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                              input logic st2, input logic bad_par, input logic stop_low,
                              input int glitch_bit);
        parity_en_i  = pen;
        parity_sel_i = podd;
        stop_sel_i   = st2;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                data_i = d[i];
                repeat (18) @(negedge clk_i);
                data_i = ~d[i];
                repeat (2) @(negedge clk_i);
                data_i = d[i];
                repeat (c_bit - 20) @(negedge clk_i);
            end else begin
                drive_bit(d[i]);
            end
        end
        if (pen) drive_bit((^d) ^ podd ^ bad_par);
        drive_bit(~stop_low);
        if (st2) drive_bit(1'b1);
        data_i = 1'b1;
    endtask

    task automatic wait_rx(input string tag, input int n);
        int k;
        k = 0;
        while ((rx_q.size() < n) && (k < 20 * c_bit)) begin
            @(negedge clk_i);
            k++;
        end
        check(tag, rx_q.size(), n);
    endtask

    task automatic pop_check(input string tag);
        rx_t got;
        rx_t exp;
        if ((rx_q.size() > 0) && (exp_q.size() > 0)) begin
            got = rx_q.pop_front();
            exp = exp_q.pop_front();
            check({tag, "_data"}, {24'h0, got.d}, {24'h0, exp.d});
            check({tag, "_flags"}, {29'h0, got.p, got.f, got.n}, {29'h0, exp.p, exp.f, exp.n});
        end else begin
            check({tag, "_avail"}, rx_q.size(), 1);
        end
    endtask

    initial begin
        rst_n_i      = 1'b0;
        enable_i     = 1'b1;
        data_i       = 1'b1;
        parity_en_i  = 1'b0;
        parity_sel_i = 1'b0;
        stop_sel_i   = 1'b0;
        data_ready_i = 1'b1;
        repeat (4) @(negedge clk_i);

        // Reset state
        check("rst_data",  {24'h0, data_o}, 32'h0);
        check("rst_valid", {31'h0, data_valid_o}, 32'h0);
        check("rst_busy",  {31'h0, busy_o}, 32'h0);
        check("rst_errs",  {28'h0, parity_err_o, framing_err_o, noise_err_o, overrun_err_o}, 32'h0);
        rst_n_i = 1'b1;
        idle_bits(2);

        // 'H', odd parity, 1 stop, ready high: clean byte, valid for one clock
        vcycles = 0;
        exp_q.push_back('{d: 8'h48, p: 1'b0, f: 1'b0, n: 1'b0});
        send_frame(8'h48, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        idle_bits(2);
        wait_rx("h_rx", 1);
        pop_check("h");
        check("h_valid_cycles", vcycles, 1);

        // 'E', even parity, wrong parity bit
        exp_q.push_back('{d: 8'h45, p: 1'b1, f: 1'b0, n: 1'b0});
        send_frame(8'h45, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle_bits(2);
        wait_rx("e_rx", 1);
        pop_check("e");

        // 8'hA5 with stop low, then clean 8'h3C with two stop bits
        exp_q.push_back('{d: 8'hA5, p: 1'b0, f: 1'b1, n: 1'b0});
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle_bits(2);
        wait_rx("a5_rx", 1);
        pop_check("a5");
        exp_q.push_back('{d: 8'h3C, p: 1'b0, f: 1'b0, n: 1'b0});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        idle_bits(2);
        wait_rx("3c_rx", 1);
        pop_check("3c");

        // False start: low for 3/16 bit
        busy_seen = 1'b0;
        data_i = 1'b0;
        repeat (6) @(negedge clk_i);
        idle_bits(2);
        check("fs_busy_seen", {31'h0, busy_seen}, 32'h1);
        check("fs_busy_now",  {31'h0, busy_o}, 32'h0);
        check("fs_valid",     {31'h0, data_valid_o}, 32'h0);
        check("fs_no_rx",     rx_q.size(), 0);

        // Overrun: two frames with ready low
        data_ready_i = 1'b0;
        ovr_cnt = 0;
        exp_q.push_back('{d: 8'h11, p: 1'b0, f: 1'b0, n: 1'b0});
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle_bits(1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle_bits(2);
        check("ovr_data",  {24'h0, data_o}, 32'h11);
        check("ovr_valid", {31'h0, data_valid_o}, 32'h1);
        check("ovr_pulses", ovr_cnt, 1);
        data_ready_i = 1'b1;
        wait_rx("ovr_rx", 1);
        pop_check("ovr");

        // enable dropped mid-frame: frame still completes
        exp_q.push_back('{d: 8'h96, p: 1'b0, f: 1'b0, n: 1'b0});
        fork
            send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
            begin
                repeat (3 * c_bit) @(negedge clk_i);
                enable_i = 1'b0;
            end
        join
        idle_bits(2);
        wait_rx("en_rx", 1);
        pop_check("en");
        enable_i = 1'b1;

        // Async reset mid-frame with a byte held
        data_ready_i = 1'b0;
        send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle_bits(1);
        data_i = 1'b0;
        repeat (3 * c_bit) @(negedge clk_i);
        check("ar_busy_before", {31'h0, busy_o}, 32'h1);
        #2 rst_n_i = 1'b0;
        #1;
        check("ar_busy",  {31'h0, busy_o}, 32'h0);
        check("ar_valid", {31'h0, data_valid_o}, 32'h0);
        check("ar_data",  {24'h0, data_o}, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        data_ready_i = 1'b1;
        idle_bits(2);
        check("ar_no_rx", rx_q.size(), 0);

        // Clean frame after reset: odd parity, two stop bits
        exp_q.push_back('{d: 8'hC3, p: 1'b0, f: 1'b0, n: 1'b0});
        send_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        idle_bits(2);
        wait_rx("c3_rx", 1);
        pop_check("c3");

`ifdef UART_RX_NOISE_DETECT_EN
        // One-sample glitch at mid bit 3 of 8'h0F
        exp_q.push_back('{d: 8'h0F, p: 1'b0, f: 1'b0, n: 1'b1});
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        idle_bits(2);
        wait_rx("nz_rx", 1);
        pop_check("nz");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
